// File: rtl/xor_chk_pkg.sv
// Shared definitions for the exhaustive XOR checker: state encoding,
// vector/counter widths and small combinational helpers.
package xor_chk_pkg;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;
  localparam int ERR_W   = 3;
  localparam int CNT_W   = 8;

  localparam logic [VEC_W-1:0] LAST_VEC = 2'd3;
  localparam logic [ERR_W-1:0] ERR_MAX  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } xor_state_e;

  // Golden response for a given operand pair {a,b}.
  function automatic logic expected_z(input logic [VEC_W-1:0] vec);
    return vec[1] ^ vec[0];
  endfunction

  // Error counter increment that saturates at the number of vectors.
  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] cnt);
    logic [ERR_W-1:0] res;
    if (cnt >= ERR_MAX) begin
      res = cnt;
    end else begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each vector is held before
// the response is sampled. Stops at zero and flags it.
module settle_timer
  import xor_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Counter register: load has priority over decrement, never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign value = count_r;
  assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/xor_checker.sv
// Exhaustive tester for a 2-input XOR device: drives all four operand
// pairs, lets each settle, samples the response and records mismatches.
module xor_checker
  import xor_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [NUM_VEC-1:0] fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  xor_state_e         state_r, state_s;
  logic [VEC_W-1:0]   vec_r, vec_s;
  logic [ERR_W-1:0]   err_r, err_s;
  logic [NUM_VEC-1:0] fail_r, fail_s;
  logic               mismatch_s;
  logic               tmr_load_s, tmr_dec_s, tmr_zero_s;
  logic [CNT_W-1:0]   tmr_value_s;
  logic               busy_s, done_s, pass_s, a_s, b_s;
  logic               busy_r, done_r, pass_r, a_r, b_r;

  settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .dec        (tmr_dec_s),
    .load_value (SETTLE_LOAD),
    .value      (tmr_value_s),
    .zero       (tmr_zero_s)
  );

  assign tmr_dec_s = (state_r == ST_SETTLE) && (tmr_value_s != {CNT_W{1'b0}});

  // State register together with the run's vector index and result records.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      vec_r   <= {VEC_W{1'b0}};
      err_r   <= {ERR_W{1'b0}};
      fail_r  <= {NUM_VEC{1'b0}};
    end else begin
      state_r <= state_s;
      vec_r   <= vec_s;
      err_r   <= err_s;
      fail_r  <= fail_s;
    end
  end

  // Next-state logic: start acceptance, settle wait, sample and advance.
  always_comb begin
    state_s    = state_r;
    vec_s      = vec_r;
    err_s      = err_r;
    fail_s     = fail_r;
    tmr_load_s = 1'b0;
    mismatch_s = (z_in != expected_z(vec_r));
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s    = ST_SETTLE;
          vec_s      = {VEC_W{1'b0}};
          err_s      = {ERR_W{1'b0}};
          fail_s     = {NUM_VEC{1'b0}};
          tmr_load_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero_s) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          fail_s[vec_r] = 1'b1;
          err_s         = sat_inc_err(err_r);
        end else begin
          err_s = err_r;
        end
        if ((vec_r == LAST_VEC) || (mismatch_s && STOP_ON_FAIL)) begin
          state_s = ST_DONE;
        end else begin
          vec_s      = vec_r + 2'd1;
          tmr_load_s = 1'b1;
          state_s    = ST_SETTLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    busy_s = (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
    done_s = (state_s == ST_DONE);
    pass_s = done_s && (err_s == 3'd0);
    if (busy_s) begin
      a_s = vec_s[1];
      b_s = vec_s[0];
    end else begin
      a_s = 1'b0;
      b_s = 1'b0;
    end
  end

  // Output registers so the device under test sees glitch-free operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
      a_r    <= 1'b0;
      b_r    <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      pass_r <= pass_s;
      a_r    <= a_s;
      b_r    <= b_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign a_out     = a_r;
  assign b_out     = b_r;
  assign err_count = err_r;
  assign fail_vec  = fail_r;

endmodule

// File: tb/tb_xor_checker.sv
// Bench for xor_checker: three instances (settle 4 / settle 4 stop-on-fail /
// settle 1) drive a device model given by a 4-entry truth table.
module tb_xor_checker;

  localparam int S_AB = 4;
  localparam int S_C  = 1;
  localparam int MAXC = 24;

  typedef struct {
    logic [3:0] tt;
    int done_a; int err_a; int fv_a; int pass_a;
    int done_b; int err_b; int fv_b;
  } row_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] tt;
  logic a_a, b_a, z_a, busy_a, done_a, pass_a; logic [2:0] err_a; logic [3:0] fv_a;
  logic a_b, b_b, z_b, busy_b, done_b, pass_b; logic [2:0] err_b; logic [3:0] fv_b;
  logic a_c, b_c, z_c, busy_c, done_c, pass_c; logic [2:0] err_c; logic [3:0] fv_c;
  int n_tests = 0;
  int n_fail  = 0;
  row_t rows[4];

  always #5 clk = ~clk;

  assign z_a = tt[{a_a, b_a}];
  assign z_b = tt[{a_b, b_b}];
  assign z_c = tt[{a_c, b_c}];

  xor_checker #(.SETTLE_CYCLES(S_AB), .STOP_ON_FAIL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .a_out(a_a), .b_out(b_a), .z_in(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fv_a));
  xor_checker #(.SETTLE_CYCLES(S_AB), .STOP_ON_FAIL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .a_out(a_b), .b_out(b_b), .z_in(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fv_b));
  xor_checker #(.SETTLE_CYCLES(S_C), .STOP_ON_FAIL(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .a_out(a_c), .b_out(b_c), .z_in(z_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_vec(fv_c));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: which vectors mismatch for truth table t (only the first when sof).
  function automatic logic [3:0] m_fail(input logic [3:0] t, input bit sof);
    logic [3:0] r = 4'b0000;
    bit seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int zx = (i / 2) ^ (i % 2);
      if ((int'(t[i]) != zx) && !(sof && seen)) begin
        r[i] = 1'b1;
        seen = 1'b1;
      end
    end
    return r;
  endfunction

  // Reference: number of vectors the run covers before reaching DONE.
  function automatic int m_nvec(input logic [3:0] t, input bit sof);
    logic [3:0] f = m_fail(t, sof);
    int n = 4;
    if (sof) begin
      for (int i = 3; i >= 0; i--) if (f[i]) n = i + 1;
    end
    return n;
  endfunction

  // Reference: {busy,done,a,b} seen k cycles after the start cycle.
  function automatic logic [3:0] exp_obs(input int k, input int s, input int nvec);
    int last = nvec * (s + 1);
    int v;
    logic [3:0] r;
    if (k >= 1 && k <= last) begin
      v = (k - 1) / (s + 1);
      r = {1'b1, 1'b0, v[1], v[0]};
    end else if (k > last) begin
      r = 4'b0100;
    end else begin
      r = 4'b0000;
    end
    return r;
  endfunction

  task automatic run(input logic [3:0] t, input int rp1, input int rp2, input int rst_at,
                     input bit chk_c, output int dc_a, output int dc_b, output int dc_c);
    int nv_a, nv_b, nv_c;
    nv_a = m_nvec(t, 1'b0);
    nv_b = m_nvec(t, 1'b1);
    nv_c = m_nvec(t, 1'b0);
    dc_a = -1; dc_b = -1; dc_c = -1;
    tt = t;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      if (done_a && dc_a < 0) dc_a = k;
      if (done_b && dc_b < 0) dc_b = k;
      if (done_c && dc_c < 0) dc_c = k;
      if (k == 1) begin
        check("clear_a", {err_a, fv_a}, 0);
        check("clear_b", {err_b, fv_b}, 0);
      end
      if (rst_at < 0) begin
        check($sformatf("obs_a t=%b k=%0d", t, k), {busy_a, done_a, a_a, b_a}, exp_obs(k, S_AB, nv_a));
        check($sformatf("obs_b t=%b k=%0d", t, k), {busy_b, done_b, a_b, b_b}, exp_obs(k, S_AB, nv_b));
        if (chk_c)
          check($sformatf("obs_c t=%b k=%0d", t, k), {busy_c, done_c, a_c, b_c}, exp_obs(k, S_C, nv_c));
      end else if (k == rst_at + 1) begin
        check("rst_mid_a", {busy_a, done_a, pass_a, a_a, b_a, err_a, fv_a}, 0);
        check("rst_mid_b", {busy_b, done_b, pass_b, a_b, b_b, err_b, fv_b}, 0);
      end
      start = (k == rp1) || (k == rp2);
      rst   = (k == rst_at);
    end
  endtask

  task automatic check_final(input string tag, input logic [3:0] t,
                             input int dca, input int dcb, input int dcc);
    logic [3:0] fa, fb;
    fa = m_fail(t, 1'b0);
    fb = m_fail(t, 1'b1);
    check({tag, " done_a"}, dca, m_nvec(t, 1'b0) * (S_AB + 1) + 1);
    check({tag, " fv_a"}, fv_a, fa);
    check({tag, " err_a"}, err_a, $countones(fa));
    check({tag, " pass_a"}, pass_a, (fa == 4'b0000) ? 1 : 0);
    check({tag, " done_b"}, dcb, m_nvec(t, 1'b1) * (S_AB + 1) + 1);
    check({tag, " fv_b"}, fv_b, fb);
    check({tag, " err_b"}, err_b, $countones(fb));
    check({tag, " done_c"}, dcc, m_nvec(t, 1'b0) * (S_C + 1) + 1);
    check({tag, " fv_c"}, fv_c, fa);
    check({tag, " pass_c"}, pass_c, (fa == 4'b0000) ? 1 : 0);
  endtask

  initial begin
    int dca, dcb, dcc;
    logic [3:0] t;
    rows[0] = '{4'b0110, 21, 0, 4'b0000, 1, 21, 0, 4'b0000};
    rows[1] = '{4'b0000, 21, 2, 4'b0110, 0, 11, 1, 4'b0010};
    rows[2] = '{4'b1001, 21, 4, 4'b1111, 0,  6, 1, 4'b0001};
    rows[3] = '{4'b1111, 21, 2, 4'b1001, 0,  6, 1, 4'b0001};

    rst = 1'b1; start = 1'b0; tt = 4'b0110;
    repeat (3) @(negedge clk);
    check("reset_a", {busy_a, done_a, pass_a, a_a, b_a, err_a, fv_a}, 0);
    check("reset_b", {busy_b, done_b, pass_b, a_b, b_b, err_b, fv_b}, 0);
    check("reset_c", {busy_c, done_c, pass_c, a_c, b_c, err_c, fv_c}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run(rows[i].tt, -1, -1, -1, 1'b1, dca, dcb, dcc);
      check($sformatf("row%0d done_a", i), dca, rows[i].done_a);
      check($sformatf("row%0d err_a", i), err_a, rows[i].err_a);
      check($sformatf("row%0d fv_a", i), fv_a, rows[i].fv_a);
      check($sformatf("row%0d pass_a", i), pass_a, rows[i].pass_a);
      check($sformatf("row%0d done_b", i), dcb, rows[i].done_b);
      check($sformatf("row%0d err_b", i), err_b, rows[i].err_b);
      check($sformatf("row%0d fv_b", i), fv_b, rows[i].fv_b);
      check($sformatf("row%0d pass_b", i), pass_b, (rows[i].err_b == 0) ? 1 : 0);
      check($sformatf("row%0d c_fv", i), fv_c, m_fail(rows[i].tt, 1'b0));
    end

    for (int i = 0; i < 12; i++) begin
      t = 4'($urandom);
      run(t, -1, -1, -1, 1'b1, dca, dcb, dcc);
      check_final($sformatf("rand%0d t=%b", i, t), t, dca, dcb, dcc);
    end

    // start re-pulsed mid-run must not restart the 4-cycle-settle instances
    run(4'b0110, 3, 10, -1, 1'b0, dca, dcb, dcc);
    check("repulse done_a", dca, 21);
    check("repulse done_b", dcb, 21);
    check("repulse pass_a", pass_a, 1);

    // reset mid-run: no done, then a clean full run
    run(4'b0110, -1, -1, 12, 1'b0, dca, dcb, dcc);
    check("rst_run no_done_a", dca, -1);
    check("rst_run no_done_b", dcb, -1);
    run(4'b0110, -1, -1, -1, 1'b1, dca, dcb, dcc);
    check_final("after_rst", 4'b0110, dca, dcb, dcc);

    // failing run followed by a restart from DONE with a correct device
    run(4'b1001, -1, -1, -1, 1'b1, dca, dcb, dcc);
    check_final("fail_run", 4'b1001, dca, dcb, dcc);
    run(4'b0110, -1, -1, -1, 1'b1, dca, dcb, dcc);
    check_final("rerun", 4'b0110, dca, dcb, dcc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_checker.md
XOR_CHECKER -- requirements
Module: xor_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles each vector is held before z is sampled (legal range 1..255).
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0; when set to 1, the run ends at the first mismatch.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin an exhaustive run.
REQ-006 SHALL have port a_out, output, 1 bit: operand a driven to the device under test.
REQ-007 SHALL have port b_out, output, 1 bit: operand b driven to the device under test.
REQ-008 SHALL have port z_in, input, 1 bit: response from the device under test.
REQ-009 SHALL have port busy, output, 1 bit: a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: the run is complete; held until restart or reset.
REQ-011 SHALL have port pass, output, 1 bit: done and no mismatches.
REQ-012 SHALL have port err_count, output, 3 bits: number of mismatching vectors (0..4).
REQ-013 SHALL have port fail_vec, output, 4 bits: bit i is set when vector i ({a,b}=i) mismatched.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, on the next edge enter SETTLE with vec=0, clear err_count and fail_vec, and load the settle counter with SETTLE_CYCLES-1.
REQ-016 SHALL drive a_out=vec[1] and b_out=vec[0] continuously from registers, stable for all of SETTLE and SAMPLE.
REQ-017 SHALL, in SETTLE, decrement the counter each cycle and move to SAMPLE on the cycle after the counter reads 0.
REQ-018 SHALL, in SAMPLE, compare z_in with vec[1]^vec[0]; on mismatch it sets fail_vec[vec] and increments err_count, with saturation at 4.
REQ-019 SHALL, after SAMPLE, go to DONE when vec==3 (or on a mismatch when STOP_ON_FAIL=1); otherwise it increments vec, reloads the counter, and returns to SETTLE.
REQ-020 SHALL occupy SETTLE_CYCLES+1 cycles per vector; with start sampled at cycle 0, done first reads 1 at cycle 4*(SETTLE_CYCLES+1)+1.
REQ-021 SHALL assert busy exactly in SETTLE and SAMPLE; SHALL assert done exactly in DONE; SHALL assert pass = done AND err_count==0.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL hold err_count and fail_vec stable in DONE until the next accepted start.
REQ-024 SHALL drive a_out=0 and b_out=0 in IDLE and DONE.

Reset
REQ-025 SHALL, when rst=1 on a clock edge, enter IDLE with vec=0, counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-026 SHALL let rst override start and any in-progress run; a reset mid-run discards partial results with no done pulse.

Structure
REQ-027 SHALL place the state encodings (2-bit), NUM_VEC=4 and the counter width in the shared package xor_chk_pkg.
REQ-028 SHALL implement the settle down-counter as sub-module settle_timer, with load, value, and zero-flag outputs.

Verification
REQ-029 SHALL cover: SETTLE_CYCLES=4, correct XOR model, start pulse at cycle 0 -> done=1 at cycle 21, pass=1, err_count=0, fail_vec=0000.
REQ-030 SHALL cover: z_in stuck at 0 -> done=1, pass=0, err_count=2, fail_vec=0110.
REQ-031 SHALL cover: XNOR model, STOP_ON_FAIL=0 -> err_count=4, fail_vec=1111; with STOP_ON_FAIL=1 -> done at cycle 6, err_count=1, fail_vec=0001.
REQ-032 SHALL cover: start re-pulsed at cycle 3 and cycle 10 during a run -> ignored, with done still at cycle 21.
REQ-033 SHALL cover: rst=1 at cycle 12 of a run -> next cycle all outputs at reset values; a new start gives a full run with done 21 cycles later.
REQ-034 SHALL cover: start in DONE after a failing run -> err_count and fail_vec clear on the next edge, and the rerun with a correct model ends with pass=1.
